bus_checker: RTL and testbench
==============================

# bus_checker

Synthesizable scoreboard that checks a multi-terminal bus for end-to-end delivery. Every packet a driver injects is recorded with its timestamp; every packet a monitor observes at a destination terminal is matched against the recorded set. Each observation produces one pass/fail verdict with transit latency, plus running statistics. The block sits beside the bus under test, fed by driver-side and monitor-side taps.

## Interface
- `DRVRS`, default 4: number of bus terminals; source and destination ids range 0..DRVRS-1.
- `PCKG_SZ`, default 16: packet width. Bits [PCKG_SZ-1:PCKG_SZ-8] hold the destination id; the low PCKG_SZ-8 bits are payload.
- `DEPTH`, default 16: number of outstanding expected packets.
- `TS_W`, default 32: width of the timestamp and latency fields.

Ports (SW = $clog2(DRVRS), CW = $clog2(DEPTH+1)):
- `clk`  in  1: single clock, rising edge.
- `rst_n`  in  1: reset, asynchronous and active-low.
- `drv_valid`  in  1: a driver injected a packet.
- `drv_ready`  out  1: the table can accept a packet.
- `drv_src`  in  SW: injecting terminal.
- `drv_data`  in  PCKG_SZ: injected packet.
- `mon_valid`  in  1: a monitor observed a packet; always accepted.
- `mon_dst`  in  SW: terminal where the packet arrived.
- `mon_data`  in  PCKG_SZ: observed packet.
- `res_valid`  out  1: one-cycle verdict strobe.
- `res_code`  out  2: verdict code (see Operation).
- `res_src`  out  SW: source of the matched entry; 0 if there is no match.
- `res_data`  out  PCKG_SZ: packet being judged.
- `res_latency`  out  TS_W: observation time minus injection time; 0 if there is no match.
- `pending`  out  CW: number of outstanding entries.
- `pass_cnt`, `fail_cnt`  out  16 each: saturating verdict counters.

## Operation
- Free-running timestamp `now`: 0 after reset, +1 every cycle, wraps modulo 2^TS_W.
- **Driver accept** (`drv_valid && drv_ready`):
  - If the destination id is below DRVRS: append {src, data, now} at the tail of the table.
  - Otherwise: nothing is stored and a verdict with code BAD_ID is emitted.
- **Monitor observation** (`mon_valid`): search all valid entries for the oldest one whose data equals `mon_data`, and require the packet's destination id to equal `mon_dst`.
  - **Hit**: code PASS; latency = now − entry timestamp, computed modulo 2^TS_W; the entry is removed and younger entries compact one slot toward the head, preserving age order.
  - **Data found but dest id ≠ `mon_dst`**: code MISROUTE; nothing is removed.
  - **No data match**: code NO_MATCH.
- Verdict codes: PASS=0, NO_MATCH=1, MISROUTE=2, BAD_ID=3. PASS increments `pass_cnt`; every other code increments `fail_cnt`. Both counters saturate at 0xFFFF.
- **Simultaneous accept and observation in one cycle**:
  - The search only sees entries present before this cycle.
  - Removal and append both take effect.
  - The monitor verdict wins the result port; a BAD_ID verdict on the same cycle is counted in `fail_cnt` but not presented on the port.
- `drv_ready` = (pending < DEPTH). It is a combinational function of state only and does not depend on a same-cycle removal.

## Timing
- Verdict latency: a verdict is registered and appears 1 cycle after the triggering input; `res_valid` is high for exactly that cycle.
- Sustained throughput: one driver accept and one monitor observation per cycle.
- `pending` updates on the same edge as the table update.
- **Full table**: `drv_ready`=0. A `drv_valid` without ready is ignored; the external source must hold the packet.
- **Empty table**: any observation yields NO_MATCH.
- **Wrap-around**: latency is correct across a `now` wrap as long as the true latency is below 2^TS_W.
- **Reset values**: asserting `rst_n` low at any time, including mid-operation, clears the table, `now`, `pending`, the counters and all `res_*` outputs to 0. `drv_ready` reads 1 while reset is asserted and after release.

## Structure
- Package `bus_checker_pkg` holds:
  - the `res_code_e` enum;
  - the constant `ID_W = 8`;
  - the entry struct {src, data, ts, valid}.
- Sub-module `bus_checker_sb` contains:
  - the compacting entry table;
  - the parallel data/id comparators and the oldest-first priority select;
  - the outputs hit, misroute, hit_idx and the entry fields.
- The top level holds the timestamp counter, verdict register and statistics.

## Test plan
Defaults apply throughout; "t" is the cycle count after reset release.

- **In-order delivery.** Drive 0x00FF, 0x01AB, 0x02CC, 0x00DA at t=5, 10, 15, 20. Then observe them at t=40, 45, 50, 55 with `mon_dst` = 0, 1, 2, 0. Required: four PASS verdicts, latencies 35, 35, 35, 35, `pass_cnt`=4, `pending`=0.
- **Spurious packet.** Observe 0x0155 with an empty table. Required: NO_MATCH, `res_latency`=0, `fail_cnt`=1.
- **Misroute.** Drive 0x02CC, then observe 0x02CC with `mon_dst`=1. Required: MISROUTE, `pending` stays 1. A later observation with `mon_dst`=2 gives PASS.
- **Duplicates and illegal id.** Drive 0x00FF twice (t=5, t=8), then observe it at t=20. Required: PASS with latency 15, and the t=8 entry remains. Separately, driving 0x07AA gives BAD_ID and nothing is stored.
- **Full table.** Fill 16 entries. Required: `drv_ready`=0 and a 17th drive is ignored. One PASS observation restores `drv_ready` the next cycle.
- **Reset mid-operation.** Assert `rst_n` low with 5 entries pending and a verdict in flight. Required: all outputs are 0 at once. After release, observing an old packet yields NO_MATCH.

Source files
------------

// File: rtl/bus_checker_pkg.sv
// rtl/bus_checker_pkg.sv - shared types for the bus delivery scoreboard
package bus_checker_pkg;
   localparam int ID_W      = 8;
   // Entry fields are sized for the widest supported configuration; narrower blocks zero-extend into them.
   localparam int MAX_PKT_W = 64;
   localparam int MAX_TS_W  = 64;

   typedef enum logic [1:0] {
      RES_PASS     = 2'd0,
      RES_NO_MATCH = 2'd1,
      RES_MISROUTE = 2'd2,
      RES_BAD_ID   = 2'd3
   } res_code_e;

   typedef struct packed {
      logic [ID_W-1:0]      src;
      logic [MAX_PKT_W-1:0] data;
      logic [MAX_TS_W-1:0]  ts;
      logic                 valid;
   } entry_t;
endpackage

// File: rtl/bus_checker_sb.sv
// rtl/bus_checker_sb.sv - compacting table of outstanding packets, oldest at slot 0
// Searches all slots in parallel and reports the oldest data match.
module bus_checker_sb
   import bus_checker_pkg::*;
#(
   parameter int DRVRS   = 4,
   parameter int PCKG_SZ = 16,
   parameter int DEPTH   = 16,
   parameter int TS_W    = 32,
   localparam int SW = $clog2(DRVRS),
   localparam int IW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic               clk_i,
   input  logic               rst_ni,
   input  logic               push_i,
   input  logic [SW-1:0]      push_src_i,
   input  logic [PCKG_SZ-1:0] push_data_i,
   input  logic [TS_W-1:0]    push_ts_i,
   input  logic               srch_i,
   input  logic [SW-1:0]      srch_dst_i,
   input  logic [PCKG_SZ-1:0] srch_data_i,
   output logic               hit_o,
   output logic               misroute_o,
   output logic [IW-1:0]      hit_idx_o,
   output logic [SW-1:0]      hit_src_o,
   output logic [TS_W-1:0]    hit_ts_o,
   output logic [CW-1:0]      count_o
);
   entry_t           table_q [DEPTH];
   entry_t           table_d [DEPTH];
   logic [CW-1:0]    count_q, count_d, count_kept;
   logic [DEPTH-1:0] match;
   logic             found, dst_ok, remove;

   always_comb begin
      match = '0;
      for (int i = 0; i < DEPTH; i++)
         match[i] = table_q[i].valid && (table_q[i].data == MAX_PKT_W'(srch_data_i));
   end

   // Lowest slot is the oldest, so the last assignment of the descending scan wins.
   always_comb begin
      hit_idx_o = '0;
      for (int i = DEPTH - 1; i >= 0; i--)
         if (match[i]) hit_idx_o = IW'(i);
   end

   assign found      = |match;
   assign dst_ok     = srch_data_i[PCKG_SZ-1 -: ID_W] == ID_W'(srch_dst_i);
   assign hit_o      = found && dst_ok;
   assign misroute_o = found && !dst_ok;
   assign hit_src_o  = SW'(table_q[hit_idx_o].src);
   assign hit_ts_o   = TS_W'(table_q[hit_idx_o].ts);
   assign remove     = srch_i && hit_o;
   assign count_o    = count_q;
   assign count_kept = count_q - CW'(remove);

   always_comb begin
      for (int i = 0; i < DEPTH - 1; i++)
         table_d[i] = (remove && i >= int'(hit_idx_o)) ? table_q[i + 1] : table_q[i];
      table_d[DEPTH-1] = remove ? '0 : table_q[DEPTH-1];
      // The new entry lands just past the survivors, after any compaction.
      for (int i = 0; i < DEPTH; i++)
         if (push_i && i == int'(count_kept))
            table_d[i] = '{src:   ID_W'(push_src_i),
                           data:  MAX_PKT_W'(push_data_i),
                           ts:    MAX_TS_W'(push_ts_i),
                           valid: 1'b1};
      count_d = count_kept + CW'(push_i);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         count_q <= '0;
         for (int i = 0; i < DEPTH; i++) table_q[i] <= '0;
      end else begin
         count_q <= count_d;
         for (int i = 0; i < DEPTH; i++) table_q[i] <= table_d[i];
      end
   end
endmodule

// File: rtl/bus_checker.sv
// rtl/bus_checker.sv - end-to-end delivery scoreboard for a multi-terminal bus
// Holds the timestamp, the registered verdict and saturating statistics around the entry table.
module bus_checker
   import bus_checker_pkg::*;
#(
   parameter int DRVRS   = 4,
   parameter int PCKG_SZ = 16,
   parameter int DEPTH   = 16,
   parameter int TS_W    = 32,
   localparam int SW = $clog2(DRVRS),
   localparam int IW = $clog2(DEPTH),
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               drv_valid,
   output logic               drv_ready,
   input  logic [SW-1:0]      drv_src,
   input  logic [PCKG_SZ-1:0] drv_data,
   input  logic               mon_valid,
   input  logic [SW-1:0]      mon_dst,
   input  logic [PCKG_SZ-1:0] mon_data,
   output logic               res_valid,
   output logic [1:0]         res_code,
   output logic [SW-1:0]      res_src,
   output logic [PCKG_SZ-1:0] res_data,
   output logic [TS_W-1:0]    res_latency,
   output logic [CW-1:0]      pending,
   output logic [15:0]        pass_cnt,
   output logic [15:0]        fail_cnt
);
   logic [TS_W-1:0]    now_q;
   logic               accept, bad_id, push;
   logic               sb_hit, sb_misroute;
   logic [IW-1:0]      sb_hit_idx;
   logic [SW-1:0]      sb_src;
   logic [TS_W-1:0]    sb_ts;

   logic               res_valid_q, res_valid_d;
   res_code_e          res_code_q, res_code_d;
   logic [SW-1:0]      res_src_q, res_src_d;
   logic [PCKG_SZ-1:0] res_data_q, res_data_d;
   logic [TS_W-1:0]    res_lat_q, res_lat_d;
   logic [15:0]        pass_q, pass_d, fail_q, fail_d;
   logic [1:0]         fail_inc;
   logic [16:0]        fail_sum;

   assign drv_ready = pending < CW'(DEPTH);
   assign accept    = drv_valid && drv_ready;
   assign bad_id    = accept && (drv_data[PCKG_SZ-1 -: ID_W] >= ID_W'(DRVRS));
   assign push      = accept && !bad_id;

   bus_checker_sb #(
      .DRVRS   (DRVRS),
      .PCKG_SZ (PCKG_SZ),
      .DEPTH   (DEPTH),
      .TS_W    (TS_W)
   ) u_sb (
      .clk_i       (clk),
      .rst_ni      (rst_n),
      .push_i      (push),
      .push_src_i  (drv_src),
      .push_data_i (drv_data),
      .push_ts_i   (now_q),
      .srch_i      (mon_valid),
      .srch_dst_i  (mon_dst),
      .srch_data_i (mon_data),
      .hit_o       (sb_hit),
      .misroute_o  (sb_misroute),
      .hit_idx_o   (sb_hit_idx),
      .hit_src_o   (sb_src),
      .hit_ts_o    (sb_ts),
      .count_o     (pending)
   );

   // A same-cycle BAD_ID still counts as a failure but loses the result port to the monitor.
   always_comb begin
      res_valid_d = 1'b0;
      res_code_d  = RES_PASS;
      res_src_d   = '0;
      res_data_d  = '0;
      res_lat_d   = '0;
      if (mon_valid) begin
         res_valid_d = 1'b1;
         res_data_d  = mon_data;
         if (sb_hit) begin
            res_src_d = sb_src;
            res_lat_d = now_q - sb_ts;
         end else begin
            res_code_d = sb_misroute ? RES_MISROUTE : RES_NO_MATCH;
         end
      end else if (bad_id) begin
         res_valid_d = 1'b1;
         res_code_d  = RES_BAD_ID;
         res_data_d  = drv_data;
      end
   end

   always_comb begin
      pass_d = pass_q;
      if (mon_valid && sb_hit && pass_q != 16'hFFFF) pass_d = pass_q + 16'd1;
      fail_inc = {1'b0, mon_valid && !sb_hit} + {1'b0, bad_id};
      fail_sum = {1'b0, fail_q} + 17'(fail_inc);
      fail_d   = fail_sum[16] ? 16'hFFFF : fail_sum[15:0];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         now_q       <= '0;
         res_valid_q <= 1'b0;
         res_code_q  <= RES_PASS;
         res_src_q   <= '0;
         res_data_q  <= '0;
         res_lat_q   <= '0;
         pass_q      <= '0;
         fail_q      <= '0;
      end else begin
         assert (!(mon_valid && sb_hit) || (CW'(sb_hit_idx) < pending));
         now_q       <= now_q + TS_W'(1);
         res_valid_q <= res_valid_d;
         res_code_q  <= res_code_d;
         res_src_q   <= res_src_d;
         res_data_q  <= res_data_d;
         res_lat_q   <= res_lat_d;
         pass_q      <= pass_d;
         fail_q      <= fail_d;
      end
   end

   assign res_valid   = res_valid_q;
   assign res_code    = res_code_q;
   assign res_src     = res_src_q;
   assign res_data    = res_data_q;
   assign res_latency = res_lat_q;
   assign pass_cnt    = pass_q;
   assign fail_cnt    = fail_q;
endmodule

// File: tb/tb_bus_checker.sv
// tb/tb_bus_checker.sv - self-checking bench for bus_checker against a queue-based reference
module tb_bus_checker;
   localparam int DEPTH = 16;
   localparam int NDRV  = 4;
   localparam logic [1:0] C_PASS = 2'd0, C_NOMATCH = 2'd1, C_MISROUTE = 2'd2, C_BADID = 2'd3;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        drv_valid = 1'b0, mon_valid = 1'b0;
   logic [1:0]  drv_src = '0, mon_dst = '0;
   logic [15:0] drv_data = '0, mon_data = '0;
   logic        drv_ready, res_valid;
   logic [1:0]  res_code, res_src;
   logic [15:0] res_data, pass_cnt, fail_cnt;
   logic [31:0] res_latency;
   logic [4:0]  pending;

   bus_checker dut (
      .clk(clk), .rst_n(rst_n),
      .drv_valid(drv_valid), .drv_ready(drv_ready), .drv_src(drv_src), .drv_data(drv_data),
      .mon_valid(mon_valid), .mon_dst(mon_dst), .mon_data(mon_data),
      .res_valid(res_valid), .res_code(res_code), .res_src(res_src), .res_data(res_data),
      .res_latency(res_latency), .pending(pending), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [1:0]  src;
      logic [15:0] data;
      logic [31:0] ts;
   } rec_t;

   rec_t        q[$];
   logic [31:0] tnow;
   int          m_pass, m_fail;
   int          checks = 0, errors = 0;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic bump_fail();
      if (m_fail < 65535) m_fail++;
   endtask

   task automatic step(input bit dv, input logic [1:0] s, input logic [15:0] d,
                       input bit mv, input logic [1:0] dst, input logic [15:0] md);
      bit          ev, acc, bad;
      logic [1:0]  ec, es;
      logic [15:0] ed;
      logic [31:0] el;
      int          found, rm;
      @(negedge clk);
      drv_valid = dv; drv_src = s; drv_data = d;
      mon_valid = mv; mon_dst = dst; mon_data = md;
      check("drv_ready", 64'(drv_ready), 64'(q.size() < DEPTH));
      acc = dv && (q.size() < DEPTH);
      bad = acc && (d[15:8] >= NDRV);
      ev = 0; ec = 0; es = 0; ed = 0; el = 0; rm = -1;
      if (mv) begin
         ev = 1; ed = md; ec = C_NOMATCH; found = -1;
         for (int i = 0; i < q.size(); i++)
            if (found < 0 && q[i].data == md) found = i;
         if (found >= 0) begin
            if (md[15:8] == 8'(dst)) begin
               ec = C_PASS; es = q[found].src; el = tnow - q[found].ts; rm = found;
            end else ec = C_MISROUTE;
         end
         if (ec == C_PASS) begin
            if (m_pass < 65535) m_pass++;
         end else bump_fail();
      end
      if (bad) begin
         bump_fail();
         if (!mv) begin ev = 1; ec = C_BADID; ed = d; end
      end
      if (rm >= 0) q.delete(rm);
      if (acc && !bad) q.push_back('{src: s, data: d, ts: tnow});
      @(posedge clk);
      tnow++;
      #1;
      drv_valid = 1'b0; mon_valid = 1'b0;
      check("res_valid", 64'(res_valid), 64'(ev));
      if (ev) begin
         check("res_code", 64'(res_code), 64'(ec));
         check("res_src", 64'(res_src), 64'(es));
         check("res_data", 64'(res_data), 64'(ed));
         check("res_latency", 64'(res_latency), 64'(el));
      end
      check("pending", 64'(pending), 64'(q.size()));
      check("pass_cnt", 64'(pass_cnt), 64'(m_pass));
      check("fail_cnt", 64'(fail_cnt), 64'(m_fail));
   endtask

   task automatic idle(input int n);
      repeat (n) step(0, 2'd0, 16'h0, 0, 2'd0, 16'h0);
   endtask
   task automatic drv(input logic [1:0] s, input logic [15:0] d);
      step(1, s, d, 0, 2'd0, 16'h0);
   endtask
   task automatic mon(input logic [1:0] dst, input logic [15:0] md);
      step(0, 2'd0, 16'h0, 1, dst, md);
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_res_valid"}, 64'(res_valid), 64'(0));
      check({tag, "_res_code"}, 64'(res_code), 64'(0));
      check({tag, "_res_src"}, 64'(res_src), 64'(0));
      check({tag, "_res_data"}, 64'(res_data), 64'(0));
      check({tag, "_res_latency"}, 64'(res_latency), 64'(0));
      check({tag, "_pending"}, 64'(pending), 64'(0));
      check({tag, "_pass_cnt"}, 64'(pass_cnt), 64'(0));
      check({tag, "_fail_cnt"}, 64'(fail_cnt), 64'(0));
      check({tag, "_drv_ready"}, 64'(drv_ready), 64'(1));
   endtask

   task automatic finish_reset();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      q.delete(); tnow = '0; m_pass = 0; m_fail = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not complete in time");
      $fatal(1, "watchdog");
   end

   initial begin
      bit          dv, mv;
      logic [1:0]  s, dst;
      logic [15:0] d, md;
      rec_t        r;

      #2;
      check_zero("reset");
      finish_reset();

      // in-order delivery
      idle(5);  drv(2'd1, 16'h00FF);
      idle(4);  drv(2'd2, 16'h01AB);
      idle(4);  drv(2'd3, 16'h02CC);
      idle(4);  drv(2'd0, 16'h00DA);
      idle(19); mon(2'd0, 16'h00FF);
      check("inorder_lat0", 64'(res_latency), 64'(35));
      idle(4);  mon(2'd1, 16'h01AB);
      idle(4);  mon(2'd2, 16'h02CC);
      idle(4);  mon(2'd0, 16'h00DA);
      check("inorder_lat3", 64'(res_latency), 64'(35));
      check("inorder_pass_cnt", 64'(pass_cnt), 64'(4));
      check("inorder_pending", 64'(pending), 64'(0));

      // spurious packet on an empty table
      mon(2'd1, 16'h0155);
      check("spurious_code", 64'(res_code), 64'(C_NOMATCH));
      check("spurious_fail_cnt", 64'(fail_cnt), 64'(1));

      // misroute leaves the entry in place
      drv(2'd0, 16'h02CC); idle(2);
      mon(2'd1, 16'h02CC);
      check("misroute_code", 64'(res_code), 64'(C_MISROUTE));
      check("misroute_pending", 64'(pending), 64'(1));
      mon(2'd2, 16'h02CC);
      check("misroute_then_pass", 64'(res_code), 64'(C_PASS));

      // duplicates: oldest copy is consumed first
      rst_n = 1'b0;
      finish_reset();
      idle(5); drv(2'd0, 16'h00FF);
      idle(2); drv(2'd1, 16'h00FF);
      idle(11); mon(2'd0, 16'h00FF);
      check("dup_latency", 64'(res_latency), 64'(15));
      check("dup_pending", 64'(pending), 64'(1));
      drv(2'd1, 16'h07AA);
      check("badid_code", 64'(res_code), 64'(C_BADID));
      check("badid_pending", 64'(pending), 64'(1));

      // full table, a refused drive, then space freed by one PASS
      for (int i = 1; i < DEPTH; i++) drv(2'(i), {8'(i % NDRV), 8'(i)});
      check("full_ready", 64'(drv_ready), 64'(0));
      drv(2'd2, 16'h0177);
      mon(2'd0, 16'h00FF);
      check("full_after_pass_ready", 64'(drv_ready), 64'(1));

      // reset with entries pending and a verdict on the port
      rst_n = 1'b0;
      finish_reset();
      for (int i = 0; i < 5; i++) drv(2'(i), {8'(i % NDRV), 8'(8'h40 + i)});
      mon(2'd3, 16'h0399);
      rst_n = 1'b0;
      #1;
      check_zero("midreset");
      finish_reset();
      mon(2'd0, 16'h0040);
      check("post_reset_code", 64'(res_code), 64'(C_NOMATCH));

      // randomized traffic, including same-cycle accept and observation
      for (int k = 0; k < 500; k++) begin
         dv  = ($urandom_range(0, 3) != 0);
         s   = 2'($urandom);
         d   = {8'($urandom_range(0, 4)), 8'($urandom_range(0, 3))};
         mv  = ($urandom_range(0, 2) != 0);
         dst = 2'($urandom);
         md  = {8'($urandom_range(0, 3)), 8'($urandom_range(0, 3))};
         if (q.size() > 0 && $urandom_range(0, 3) != 0) begin
            r  = q[$urandom_range(0, q.size() - 1)];
            md = r.data;
            if ($urandom_range(0, 4) != 0) dst = r.data[9:8];
         end
         step(dv, s, d, mv, dst, md);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
